uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/uart_frame_buf.sv | 28 ++
 rtl/uart_frame_parser.sv | 199 +++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_frame_pkg;

    localparam int          BYTE_W           = 8;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    // Cause codes reported on err_code.
    localparam logic [1:0]  ERR_CHK = 2'b01;
    localparam logic [1:0]  ERR_LEN = 2'b10;
    localparam logic [1:0]  ERR_TMO = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_EMIT
    } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload byte store: one write port, one combinational read port.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [DEPTH];

    // Write one payload byte per strobe.
    // NOTE: the array has no reset; every entry is written before it is read, and a reset would turn cheap RAM-like storage into a wide reset tree.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SYNC/ADDR/LEN/payload/CHK frames from a byte stream and replays
// the payload of good frames on a valid/ready stream.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_clk,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic [7:0] frame_addr,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       overrun
);

    localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TW        = $clog2(TIMEOUT + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          rx_clk_q;
    logic          strobe;
    logic          in_frame;
    logic          tmo_hit;
    logic          xfer;
    logic [7:0]    addr_q, len_q, idx_q, sum_q;
    logic [TW-1:0] tmo_cnt;
    logic          ok_set, err_set, ovr_set;
    logic [1:0]    err_cause;
    logic          buf_we;
    logic [IW-1:0] rd_addr;
    logic [7:0]    rd_data;

    assign strobe   = rx_data_clk & ~rx_clk_q;
    assign in_frame = (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_DATA) || (state == S_CHK);
    assign tmo_hit  = in_frame && !strobe && (tmo_cnt == TMO_LAST);
    assign xfer     = m_valid & m_ready;
    assign buf_we   = strobe && (state == S_DATA);
    // During EMIT idx_q points at the next byte to present; at the CHK strobe byte 0 is preloaded.
    assign rd_addr  = (state == S_EMIT) ? idx_q[IW-1:0] : '0;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (IW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx_q[IW-1:0]),
        .wdata (rx_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and one-cycle event requests.
    // NOTE: every output of this block gets a default first so no path leaves a value unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        ok_set    = 1'b0;
        err_set   = 1'b0;
        ovr_set   = 1'b0;
        err_cause = ERR_CHK;
        if (tmo_hit) begin
            err_set   = 1'b1;
            err_cause = ERR_TMO;
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (strobe && rx_data == SYNC_BYTE) state_nxt = S_ADDR;
                end
                S_ADDR: begin
                    if (strobe) state_nxt = S_LEN;
                end
                S_LEN: begin
                    if (strobe) begin
                        if (rx_data > MAX_LEN_B) begin
                            err_set   = 1'b1;
                            err_cause = ERR_LEN;
                            state_nxt = S_IDLE;
                        end else if (rx_data == 8'd0) begin
                            state_nxt = S_CHK;
                        end else begin
                            state_nxt = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (strobe && idx_q == len_q - 8'd1) state_nxt = S_CHK;
                end
                S_CHK: begin
                    if (strobe) begin
                        if (rx_data == sum_q) begin
                            ok_set    = 1'b1;
                            state_nxt = (len_q == 8'd0) ? S_IDLE : S_EMIT;
                        end else begin
                            err_set   = 1'b1;
                            err_cause = ERR_CHK;
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_EMIT: begin
                    if (strobe) ovr_set = 1'b1;
                    if (xfer && m_last) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: strobe edge detect, field capture, running sum, timeout counter, output stream and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_clk_q   <= 1'b1;
            addr_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            tmo_cnt    <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_data     <= '0;
            frame_addr <= '0;
            err_code   <= '0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_clk_q  <= rx_data_clk;
            frame_ok  <= ok_set;
            frame_err <= err_set;
            overrun   <= ovr_set;
            if (err_set) err_code <= err_cause;

            if (in_frame && !strobe) tmo_cnt <= tmo_cnt + 1'b1;
            else                     tmo_cnt <= '0;

            if (strobe) begin
                case (state)
                    S_ADDR: begin
                        addr_q <= rx_data;
                        sum_q  <= rx_data;
                    end
                    S_LEN: begin
                        len_q <= rx_data;
                        sum_q <= sum_q + rx_data;
                        idx_q <= '0;
                    end
                    S_DATA: begin
                        sum_q <= sum_q + rx_data;
                        idx_q <= idx_q + 8'd1;
                    end
                    default: ;
                endcase
            end

            if (ok_set) begin
                frame_addr <= addr_q;
                if (len_q != 8'd0) begin
                    m_valid <= 1'b1;
                    m_data  <= rd_data;
                    m_last  <= (len_q == 8'd1);
                    idx_q   <= 8'd1;
                end
            end else if (state == S_EMIT && xfer) begin
                if (m_last) begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end else begin
                    m_data <= rd_data;
                    m_last <= (idx_q == len_q - 8'd1);
                    idx_q  <= idx_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser.
module tb_uart_frame_parser;
    import uart_frame_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 2000;

    typedef struct {
        logic [1:0] kind;   // 0 ok, 1 err, 2 overrun
        logic [7:0] val;    // frame_addr for ok, err_code for err
    } evt_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_data_clk;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [7:0] frame_addr;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       overrun;

    evt_t  exp_evt [$];
    beat_t exp_str [$];
    logic [7:0] pay [32];

    int n_checks = 0;
    int n_pass   = 0;
    logic rand_ready = 1'b0;

    logic       prev_hold;
    logic [7:0] prev_data;
    logic       prev_last;
    logic       prev_end;

    uart_frame_parser #(
        .SYNC_BYTE (8'hA5),
        .MAX_LEN   (MAX_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_data_clk (rx_data_clk),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .frame_addr  (frame_addr),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Monitor: compare pulses and stream beats against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
            prev_end  = 1'b0;
        end else begin
            if (frame_ok || frame_err || overrun) begin
                evt_t e;
                logic [1:0] obs_kind;
                check("pulse_exclusive", 32'(frame_ok) + 32'(frame_err) + 32'(overrun), 1);
                obs_kind = frame_ok ? 2'd0 : (frame_err ? 2'd1 : 2'd2);
                check("event_expected", 32'(exp_evt.size() != 0), 1);
                if (exp_evt.size() != 0) begin
                    e = exp_evt.pop_front();
                    check("event_kind", obs_kind, e.kind);
                    if (obs_kind == 2'd0) check("frame_addr", frame_addr, e.val);
                    if (obs_kind == 2'd1) check("err_code", err_code, e.val);
                end
            end
            if (prev_hold) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            if (prev_end) check("valid_drop", m_valid, 0);
            if (m_valid && m_ready) begin
                check("beat_expected", 32'(exp_str.size() != 0), 1);
                if (exp_str.size() != 0) begin
                    beat_t b;
                    b = exp_str.pop_front();
                    check("m_data", m_data, b.d);
                    check("m_last", m_last, b.l);
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            prev_end  = m_valid && m_ready && m_last;
        end
    end

    // Random backpressure for the mixed-frame phase.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1 m_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data     = b;
        rx_data_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rx_data_clk = 1'b0;
        @(posedge clk);
    endtask

    // Sends SYNC, addr, len, pay[0..len-1], checksum (optionally corrupted) and queues what the DUT must produce.
    task automatic send_frame(input logic [7:0] addr, input int len, input logic bad);
        logic [7:0] sum;
        sum = addr + 8'(len);
        for (int i = 0; i < len && i < 32; i++) sum = sum + pay[i];
        if (len > MAX_LEN) begin
            exp_evt.push_back('{kind: 2'd1, val: 8'(ERR_LEN)});
            send_byte(8'hA5); send_byte(addr); send_byte(8'(len));
        end else begin
            if (bad) begin
                exp_evt.push_back('{kind: 2'd1, val: 8'(ERR_CHK)});
            end else begin
                exp_evt.push_back('{kind: 2'd0, val: addr});
                for (int i = 0; i < len; i++)
                    exp_str.push_back('{d: pay[i], l: (i == len - 1)});
            end
            send_byte(8'hA5); send_byte(addr); send_byte(8'(len));
            for (int i = 0; i < len; i++) send_byte(pay[i]);
            send_byte(bad ? sum + 8'd1 : sum);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_evt.size() != 0 || exp_str.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", exp_evt.size() + exp_str.size(), 0);
        exp_evt.delete();
        exp_str.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_frame_addr"}, frame_addr, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_pulses"}, {frame_ok, frame_err, overrun}, 0);
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        rx_data     = 8'hA5;
        rx_data_clk = 1'b1;
        m_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        // Release with the byte-available level already high: must not count as a byte.
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rx_data_clk = 1'b0;
        rx_data = 8'h00;

        // Good two-byte frame.
        pay[0] = 8'h11; pay[1] = 8'h22;
        send_frame(8'h03, 2, 1'b0);
        wait_drain(200);
        check("addr_after_ok", frame_addr, 8'h03);

        // Bad checksum: error, no stream, frame_addr unchanged.
        send_frame(8'h03, 2, 1'b1);
        wait_drain(200);
        check("addr_after_chk_err", frame_addr, 8'h03);

        // Length too large, then a zero-length frame.
        send_frame(8'h01, 8'h14, 1'b0);
        wait_drain(200);
        send_frame(8'h01, 0, 1'b0);
        wait_drain(200);
        check("addr_zero_len", frame_addr, 8'h01);

        // Boundary lengths: exactly MAX_LEN accepted, MAX_LEN+1 rejected.
        for (int i = 0; i < MAX_LEN; i++) pay[i] = 8'(8'hF0 + i);
        send_frame(8'h42, MAX_LEN, 1'b0);
        wait_drain(400);
        send_frame(8'h43, MAX_LEN + 1, 1'b0);
        wait_drain(200);

        // Inter-byte timeout.
        exp_evt.push_back('{kind: 2'd1, val: 8'(ERR_TMO)});
        send_byte(8'hA5);
        send_byte(8'h07);
        n = 0;
        while (exp_evt.size() != 0 && n < TIMEOUT + 50) begin
            @(posedge clk);
            n++;
        end
        check("tmo_window", 32'(n >= TIMEOUT - 4 && n <= TIMEOUT + 2), 1);
        wait_drain(10);
        // Back in IDLE: a single-byte frame with an embedded SYNC value as data.
        pay[0] = 8'hA5;
        send_frame(8'h09, 1, 1'b0);
        wait_drain(200);

        // Backpressure: hold the stream, one extra byte during EMIT overruns.
        m_ready = 1'b0;
        pay[0] = 8'hAA; pay[1] = 8'h55;
        send_frame(8'h10, 2, 1'b0);
        exp_evt.push_back('{kind: 2'd2, val: 8'h00});
        send_byte(8'hA5);
        repeat (50) @(posedge clk);
        #1 m_ready = 1'b1;
        wait_drain(200);

        // Random frames under random backpressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            int len;
            len = $urandom_range(1, MAX_LEN);
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            send_frame(8'($urandom), len, 1'b0);
            wait_drain(600);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1 m_ready = 1'b1;

        // Reset in the middle of DATA discards the frame.
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h03); send_byte(8'h11);
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_byte(8'h00);
        pay[0] = 8'hAB;
        send_frame(8'h05, 1, 1'b0);
        wait_drain(200);
        check("addr_after_midreset", frame_addr, 8'h05);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
